// File: rtl/idli_fetch_m.sv
// SQI instruction fetch: runs the quad-SPI read sequence, owns the 2-bit sync counter and
// assembles 16-bit words for decode. Optional redirect counter under `IDLI_FETCH_PERF_EN.
module idli_fetch_m #(
    parameter logic [15:0] RST_ADDR = 16'h0000,
    parameter logic [7:0]  RD_CMD   = 8'h03
) (
    input  logic            i_fe_gck,
    input  logic            i_fe_rst_n,
    output logic [1:0]      o_fe_ctr,
    output logic [0:3][3:0] o_fe_enc,
    output logic            o_fe_enc_vld,
    output logic [15:0]     o_fe_pc,
    output logic [3:0]      o_fe_nib,
    input  logic            i_fe_redir,
    input  logic [15:0]     i_fe_redir_addr,
    output logic            o_fe_sqi_cs_n,
    output logic [3:0]      o_fe_sqi_sio,
    output logic            o_fe_sqi_oe,
    input  logic [3:0]      i_fe_sqi_sio
`ifdef IDLI_FETCH_PERF_EN
    ,
    output logic [15:0]     o_fe_redir_cnt
`endif
);

    // state  | meaning
    // IDLE   | chip deselected, waiting for ctr==2 to start a read
    // CMD    | 2 cycles, read command byte driven high nibble first
    // ADDR   | 6 cycles, 24-bit byte address driven MSB nibble first
    // DUMMY  | 2 cycles, pads released, memory turnaround
    // DATA   | streaming, one word per 4-cycle period
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      seq_q, seq_d;
    logic [1:0]      ctr_q;
    logic [15:0]     pc_q, pc_d;
    logic [0:2][3:0] buf_q;
    logic            cs_n_q, cs_n_d;
    logic            oe_q, oe_d;
    logic [3:0]      sio_q, sio_d;
    logic            redir_acc;
    logic [23:0]     byte_addr;

    assign redir_acc = (ctr_q == 2'd3) && i_fe_redir;
    assign byte_addr = {7'b0, pc_q, 1'b0};

    always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
        if (!i_fe_rst_n) begin
            state_q <= ST_IDLE;
            seq_q   <= 4'd0;
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            sio_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            cs_n_q  <= cs_n_d;
            oe_q    <= oe_d;
            sio_q   <= sio_d;
        end
    end

    // seq counts sequence cycles 0..9 across CMD/ADDR/DUMMY so the address nibble is a direct lookup
    always_comb begin
        state_d = state_q;
        seq_d   = 4'd0;
        if (redir_acc) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctr_q == 2'd1) state_d = ST_CMD;
                end
                ST_CMD: begin
                    seq_d = seq_q + 4'd1;
                    if (seq_q == 4'd1) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    seq_d = seq_q + 4'd1;
                    if (seq_q == 4'd7) state_d = ST_DUMMY;
                end
                ST_DUMMY: begin
                    seq_d = seq_q + 4'd1;
                    if (seq_q == 4'd9) state_d = ST_DATA;
                end
                ST_DATA: state_d = ST_DATA;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pad outputs are computed from the next state so the registered pins line up with it.
    always_comb begin
        cs_n_d = (state_d == ST_IDLE);
        oe_d   = (state_d == ST_CMD) || (state_d == ST_ADDR);
        sio_d  = 4'h0;
        case (state_d)
            ST_CMD: sio_d = seq_d[0] ? RD_CMD[3:0] : RD_CMD[7:4];
            ST_ADDR: begin
                case (seq_d)
                    4'd2:    sio_d = byte_addr[23:20];
                    4'd3:    sio_d = byte_addr[19:16];
                    4'd4:    sio_d = byte_addr[15:12];
                    4'd5:    sio_d = byte_addr[11:8];
                    4'd6:    sio_d = byte_addr[7:4];
                    4'd7:    sio_d = byte_addr[3:0];
                    default: sio_d = 4'h0;
                endcase
            end
            default: sio_d = 4'h0;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redir_acc) begin
            pc_d = i_fe_redir_addr;
        end else if ((state_q == ST_DATA) && (ctr_q == 2'd3)) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
        if (!i_fe_rst_n) begin
            ctr_q <= 2'd0;
            pc_q  <= RST_ADDR;
            buf_q <= '0;
        end else begin
            ctr_q <= ctr_q + 2'd1;
            pc_q  <= pc_d;
            if (state_q == ST_DATA) begin
                case (ctr_q)
                    2'd0:    buf_q[0] <= i_fe_sqi_sio;
                    2'd1:    buf_q[1] <= i_fe_sqi_sio;
                    2'd2:    buf_q[2] <= i_fe_sqi_sio;
                    default: buf_q    <= buf_q;
                endcase
            end
        end
    end

`ifdef IDLI_FETCH_PERF_EN
    logic [15:0] redir_cnt_q;

    always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
        if (!i_fe_rst_n) begin
            redir_cnt_q <= 16'd0;
        end else if (redir_acc && (redir_cnt_q != 16'hFFFF)) begin
            redir_cnt_q <= redir_cnt_q + 16'd1;
        end
    end

    assign o_fe_redir_cnt = redir_cnt_q;
`endif

    // Last nibble comes straight from the pad so the word is complete in the ctr==3 cycle.
    assign o_fe_enc      = {buf_q[0], buf_q[1], buf_q[2], i_fe_sqi_sio};
    assign o_fe_enc_vld  = (state_q == ST_DATA) && (ctr_q == 2'd3);
    assign o_fe_nib      = (state_q == ST_DATA) ? i_fe_sqi_sio : 4'h0;
    assign o_fe_ctr      = ctr_q;
    assign o_fe_pc       = pc_q;
    assign o_fe_sqi_cs_n = cs_n_q;
    assign o_fe_sqi_oe   = oe_q;
    assign o_fe_sqi_sio  = sio_q;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Scoreboard bench for idli_fetch_m: directed SQI data, redirects, pad sequence and word checks.
module tb_idli_fetch_m;

    localparam int NCYC = 70;

    logic        gck = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ctr;
    logic [15:0] enc;
    logic        enc_vld;
    logic [15:0] pc;
    logic [3:0]  nib;
    logic        redir;
    logic [15:0] redir_addr;
    logic        cs_n;
    logic [3:0]  sio_out;
    logic        oe;
    logic [3:0]  sio_in;
`ifdef IDLI_FETCH_PERF_EN
    logic [15:0] redir_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit run_done = 1'b0;
    logic [31:0] word_q[$];
    logic [3:0]  pad_q[$];

    idli_fetch_m #(.RST_ADDR(16'h0000), .RD_CMD(8'h03)) dut (
        .i_fe_gck        (gck),
        .i_fe_rst_n      (rst_n),
        .o_fe_ctr        (ctr),
        .o_fe_enc        (enc),
        .o_fe_enc_vld    (enc_vld),
        .o_fe_pc         (pc),
        .o_fe_nib        (nib),
        .i_fe_redir      (redir),
        .i_fe_redir_addr (redir_addr),
        .o_fe_sqi_cs_n   (cs_n),
        .o_fe_sqi_sio    (sio_out),
        .o_fe_sqi_oe     (oe),
        .i_fe_sqi_sio    (sio_in)
`ifdef IDLI_FETCH_PERF_EN
        ,
        .o_fe_redir_cnt  (redir_cnt)
`endif
    );

    always #5 gck = ~gck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_pad(input logic [31:0] nibs);
        for (int i = 7; i >= 0; i--) pad_q.push_back(nibs[i*4 +: 4]);
    endtask

    function automatic logic [3:0] nib_at(input int c);
        case (c)
            10: return 4'hF;
            12: return 4'hA; 13: return 4'hB; 14: return 4'hC; 15: return 4'hD;
            16: return 4'h1; 17: return 4'h2; 18: return 4'h3; 19: return 4'h4;
            32: return 4'h9; 33: return 4'h8; 34: return 4'h7; 35: return 4'h6;
            36: return 4'h0; 37: return 4'hF; 38: return 4'h1; 39: return 4'hE;
            60: return 4'hC; 61: return 4'hA; 62: return 4'hF; 63: return 4'hE;
            64: return 4'h5; 65: return 4'h6; 66: return 4'h7; 67: return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic exp_cs_n(input int c);
        return !((c >= 2 && c <= 19) || (c >= 22 && c <= 39) ||
                 (c >= 42 && c <= 47) || (c >= 50));
    endfunction

    function automatic logic exp_oe(input int c);
        return (c >= 2 && c <= 9) || (c >= 22 && c <= 29) ||
               (c >= 42 && c <= 47) || (c >= 50 && c <= 57);
    endfunction

    // Monitor: pops expectations whenever the DUT presents a word or drives the pads.
    always @(negedge gck) begin
        if (rst_n && !run_done) begin
            if (enc_vld) begin
                if (word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected actual enc=%h pc=%h required no valid", enc, pc);
                end else begin
                    logic [31:0] w;
                    w = word_q.pop_front();
                    check("word_enc", {16'h0, enc}, {16'h0, w[15:0]});
                    check("word_pc", {16'h0, pc}, {16'h0, w[31:16]});
                end
            end
            if (!cs_n && oe) begin
                if (pad_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pad_unexpected actual sio=%h required no drive", sio_out);
                end else begin
                    logic [3:0] p;
                    p = pad_q.pop_front();
                    check("pad_sio", {28'h0, sio_out}, {28'h0, p});
                end
            end
        end
    end

    initial begin
        redir      = 1'b0;
        redir_addr = 16'h0;
        sio_in     = 4'h0;
        repeat (2) @(posedge gck);
        #1;
        check("rst_ctr", {30'h0, ctr}, 32'h0);
        check("rst_cs_n", {31'h0, cs_n}, 32'h1);
        check("rst_oe", {31'h0, oe}, 32'h0);
        check("rst_sio", {28'h0, sio_out}, 32'h0);
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_enc", {16'h0, enc}, 32'h0);
        check("rst_vld", {31'h0, enc_vld}, 32'h0);
        rst_n = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            sio_in = nib_at(c);
            redir  = (c == 19) || (c == 37) || (c == 39) || (c == 47);
            case (c)
                19:      redir_addr = 16'h1234;
                37:      redir_addr = 16'h7777;
                39:      redir_addr = 16'h0050;
                47:      redir_addr = 16'hFFFF;
                default: redir_addr = 16'h0000;
            endcase
            case (c)
                2:  push_pad(32'h0300_0000);
                22: push_pad(32'h0300_2468);
                42: begin
                    pad_q.push_back(4'h0); pad_q.push_back(4'h3);
                    for (int i = 0; i < 4; i++) pad_q.push_back(4'h0);
                end
                50: push_pad(32'h0301_FFFE);
                12: word_q.push_back({16'h0000, 16'hABCD});
                16: word_q.push_back({16'h0001, 16'h1234});
                32: word_q.push_back({16'h1234, 16'h9876});
                36: word_q.push_back({16'h1235, 16'h0F1E});
                60: word_q.push_back({16'hFFFF, 16'hCAFE});
                64: word_q.push_back({16'h0000, 16'h5678});
                default: ;
            endcase

            @(negedge gck);
            check($sformatf("ctr_c%0d", c), {30'h0, ctr}, c % 4);
            check($sformatf("cs_n_c%0d", c), {31'h0, cs_n}, {31'h0, exp_cs_n(c)});
            check($sformatf("oe_c%0d", c), {31'h0, oe}, {31'h0, exp_oe(c)});
            case (c)
                10: check("nib_outside_data", {28'h0, nib}, 32'h0);
                13: check("nib_passthrough", {28'h0, nib}, 32'hB);
                16: check("pc_incr", {16'h0, pc}, 32'h0001);
                20: check("pc_redir", {16'h0, pc}, 32'h1234);
                38: check("pc_redir_ignored", {16'h0, pc}, 32'h1235);
                64: check("pc_wrap", {16'h0, pc}, 32'h0000);
                default: ;
            endcase
            @(posedge gck);
            #1;
        end

        run_done = 1'b1;
        redir    = 1'b0;
        check("words_left", word_q.size(), 32'h0);
        check("pads_left", pad_q.size(), 32'h0);
`ifdef IDLI_FETCH_PERF_EN
        check("redir_cnt", {16'h0, redir_cnt}, 32'd3);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
